usb_ep_loopback: RTL and testbench
==================================

Name: usb_ep_loopback

Overview:
Parametrised endpoint data engine on the clk60 domain. It sits between the USB device controller's endpoint data interface and user logic, and generalises the single interface/endpoint stub to NUM_EP bulk loopback endpoints and NUM_INF interface alternate-setting registers.
- OUT packets on endpoint n are stored in FIFO n; IN requests on endpoint n return that data.
- Packet-level commit/rollback supports both CRC failures and unacknowledged IN retries.

Parameters:
NUM_EP, 2, number of bulk endpoints served (endpoint numbers 1..NUM_EP; EP0 stays in the controller)
NUM_INF, 2, number of interfaces with stored alternate settings
DEPTH, 1024, bytes per endpoint FIFO (power of 2, at least 2*MPS)
MPS, 512, max packet size in bytes (512 HS bulk, 64 FS)

Ports:
clk_i  in  1  clk60 domain clock
reset_i  in  1  synchronous active-high reset
usbrst_i  in  1  bus-reset pulse from controller
rxact_i  in  1  controller OUT transfer active
rxval_i  in  1  rxdat_i byte valid
rxdat_i  in  8  OUT data byte
rxpktval_i  in  1  pulse: current OUT packet CRC good
setup_i  in  1  current packet is SETUP
endpt_i  in  4  endpoint number of current transfer
rxrdy_o  out  1  endpoint can accept a max-size packet
txact_i  in  1  controller IN transfer active
txpop_i  in  1  controller consumed txdat_o
txpktfin_i  in  1  pulse: IN packet acknowledged by host
txdat_o  out  8  IN data byte
txval_o  out  1  endpoint has committed data
txdat_len_o  out  12  IN packet length
txcork_o  out  1  NAK the IN request (no data)
inf_set_i  in  1  SET_INTERFACE strobe
inf_sel_i  in  8  interface index
inf_alter_i  in  8  new alternate setting
inf_alter_o  out  8  stored alternate setting for inf_sel_i
ovf_o  out  NUM_EP  sticky per-endpoint overflow flags

Behaviour:
- Reset: reset_i (synchronous, active-high) or usbrst_i clears all pointers, alternate-setting registers and ovf_o.
- Output values while reset is held: rxrdy_o=1, txval_o=0, txcork_o=1, txdat_len_o=0, txdat_o=0, inf_alter_o=0.
- Endpoint validity: endpoint is valid when 1<=endpt_i<=NUM_EP. Any invalid endpoint, or setup_i=1: rxrdy_o=0, txval_o=0, txcork_o=1, and writes are ignored.
- Pointer set per FIFO, each clog2(DEPTH)+1 bits wide with wrap by natural overflow: wr_sh, wr_cm, rd_sh, rd_cm.
- Derived counts: count = wr_cm - rd_cm; free = DEPTH - (wr_sh - rd_cm).
- rxrdy_o is combinational: free(endpt_i) >= MPS.
- OUT write: rxact_i & rxval_i writes mem[wr_sh] and increments wr_sh. If free=0, the byte is dropped, ovf bit n is set and the packet is marked bad.
- OUT commit: a pkt_ok flag is set by rxpktval_i. On the rxact_i falling edge (registered compare):
  - ok and not bad: wr_cm<=wr_sh.
  - otherwise: wr_sh<=wr_cm (rollback).
  - rxpktval_i in the same cycle as rxact_i falling counts as ok.
- IN path:
  - txval_o = count(endpt_i)>0; txcork_o = ~txval_o.
  - On txact_i rising, latch len = min(count, MPS); txdat_len_o holds len until txact_i falls.
  - txdat_o is a registered read of mem[rd_sh], valid whenever txval_o.
  - On txpop_i, rd_sh increments and the next byte appears on the following cycle. Back-to-back txpop_i is supported, so the read address uses rd_sh+txpop_i.
- IN commit:
  - txpktfin_i: rd_cm<=rd_sh.
  - txact_i falling with no txpktfin_i seen: rd_sh<=rd_cm, so the host retry resends identical data.
- Zero-length: count=0 at an IN gives txcork_o=1 (NAK); no zero-length packet is generated.
- Alternate settings: inf_set_i with inf_sel_i<NUM_INF writes reg[inf_sel_i]<=inf_alter_i; out-of-range selects are ignored. inf_alter_o=reg[inf_sel_i] combinationally, 0 if out of range.
- ovf_o bits clear only on reset_i or usbrst_i.

Decomposition:
- Package usb_ep_pkg: PTR_W function (clog2(DEPTH)+1), EP0 constant, HS/FS MPS constants (512/64), 12-bit length typedef.
- Sub-module usb_ep_fifo, one per endpoint via generate: memory plus the four pointers and commit/rollback logic.
- Top level holds the endpoint mux, rising/falling edge detection and the alternate-setting register file.

Test Plan:
1. Reset, then OUT 10 bytes 0x00..0x09 to EP1 with rxpktval_i -> EP1 count=10; IN on EP1 gives txval_o=1, txdat_len_o=10, bytes 0x00..0x09; after txpktfin_i, count=0 and txcork_o=1.
2. OUT 8 bytes to EP2 with no rxpktval_i -> rollback, EP2 count=0, rxrdy_o=1; EP1 unaffected.
3. IN 512 bytes from a 600-byte EP1 FIFO, txact_i falls without txpktfin_i -> retry returns identical 512 bytes with len=512; after fin, next IN has len=88.
4. Fill EP1 to 1000 bytes committed -> rxrdy_o=0; force a 30-byte write -> 24 bytes accepted then drop, ovf_o[0]=1, packet rolled back, count stays 1000.
5. inf_set_i with sel=1, alt=3, then sel=5 (out of range) -> inf_alter_o=3 for sel=1, 0 for sel=5; usbrst_i pulse -> all alternate settings 0 and FIFOs empty.
6. Access with endpt_i=0 and endpt_i=NUM_EP+1, and a SETUP packet on EP1 -> no writes, txval_o=0, rxrdy_o=0.

Source files
------------

// File: rtl/usb_ep_pkg.sv
// Shared types and constants for the endpoint loopback engine.
// Pointer width helper, packet size constants, length type.
package usb_ep_pkg;

  localparam logic [3:0] EP0 = 4'd0;
  localparam int MPS_HS = 512;
  localparam int MPS_FS = 64;

  typedef logic [11:0] len_t;

  // One extra bit so full and empty are distinguishable
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/usb_ep_fifo.sv
// Per-endpoint byte FIFO with shadow/commit pointers.
// OUT packets commit or roll back; IN packets retry until acked.
module usb_ep_fifo
  import usb_ep_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int MPS = MPS_HS,
  localparam int PW = ptr_w(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr,
  input  logic [7:0]    i_wdat,
  input  logic          i_rx_end,
  input  logic          i_rx_ok,
  input  logic          i_pop,
  input  logic          i_fin,
  input  logic          i_tx_abort,
  output logic [PW-1:0] o_count,
  output logic [PW-1:0] o_free,
  output logic [7:0]    o_rdat,
  output logic          o_ovf
);

  localparam int AW = PW - 1;

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_sh;
  logic [PW-1:0] r_wr_cm;
  logic [PW-1:0] r_rd_sh;
  logic [PW-1:0] r_rd_cm;
  logic          r_bad;
  logic          r_ovf;
  logic [7:0]    r_rdat;

  logic          w_full;
  logic          w_wr_ok;
  logic          w_pop_ok;
  logic [PW-1:0] w_rd_nxt;
  logic [PW-1:0] w_rd_addr;

  assign o_count = r_wr_cm - r_rd_cm;
  assign o_free = PW'(DEPTH) - (r_wr_sh - r_rd_cm);
  assign w_full = (o_free == '0);
  assign w_wr_ok = i_wr & ~w_full & ~i_rx_end;
  assign w_pop_ok = i_pop & (r_rd_sh != r_wr_cm);
  assign w_rd_nxt = r_rd_sh + PW'(w_pop_ok);
  assign w_rd_addr = i_tx_abort ? r_rd_cm : w_rd_nxt;
  assign o_rdat = r_rdat;
  assign o_ovf = r_ovf;

  // Pointer update: write/commit/rollback and read/ack/retry
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_sh <= '0;
      r_wr_cm <= '0;
      r_rd_sh <= '0;
      r_rd_cm <= '0;
      r_bad <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (i_rx_end) begin
        if (i_rx_ok && !r_bad) begin
          r_wr_cm <= r_wr_sh;
        end else begin
          r_wr_sh <= r_wr_cm;
        end
        r_bad <= 1'b0;
      end else if (i_wr) begin
        if (w_full) begin
          r_bad <= 1'b1;
          r_ovf <= 1'b1;
        end else begin
          r_wr_sh <= r_wr_sh + PW'(1);
        end
      end
      if (i_tx_abort) begin
        r_rd_sh <= r_rd_cm;
      end else begin
        r_rd_sh <= w_rd_nxt;
      end
      if (i_fin) begin
        r_rd_cm <= w_rd_nxt;
      end
    end
  end

  // Byte storage write port
  always_ff @(posedge i_clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_sh[AW-1:0]] <= i_wdat;
    end
  end

  // Registered read tracks the next shadow read pointer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdat <= '0;
    end else begin
      r_rdat <= r_mem[w_rd_addr[AW-1:0]];
    end
  end

endmodule

// File: rtl/usb_ep_loopback.sv
// Bulk loopback endpoint engine on the clk60 domain.
// Endpoint mux, transfer edge detect, alternate settings.
module usb_ep_loopback
  import usb_ep_pkg::*;
#(
  parameter int NUM_EP = 2,
  parameter int NUM_INF = 2,
  parameter int DEPTH = 1024,
  parameter int MPS = MPS_HS
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              usbrst_i,
  input  logic              rxact_i,
  input  logic              rxval_i,
  input  logic [7:0]        rxdat_i,
  input  logic              rxpktval_i,
  input  logic              setup_i,
  input  logic [3:0]        endpt_i,
  output logic              rxrdy_o,
  input  logic              txact_i,
  input  logic              txpop_i,
  input  logic              txpktfin_i,
  output logic [7:0]        txdat_o,
  output logic              txval_o,
  output logic [11:0]       txdat_len_o,
  output logic              txcork_o,
  input  logic              inf_set_i,
  input  logic [7:0]        inf_sel_i,
  input  logic [7:0]        inf_alter_i,
  output logic [7:0]        inf_alter_o,
  output logic [NUM_EP-1:0] ovf_o
);

  localparam int PW = ptr_w(DEPTH);

  logic          w_rst;
  logic          w_rx_fall;
  logic          w_rx_ok;
  logic          w_tx_rise;
  logic          w_tx_fall;
  logic          w_any_sel;
  logic [NUM_EP-1:0] w_sel;
  logic [PW-1:0] w_cnt [NUM_EP];
  logic [PW-1:0] w_free [NUM_EP];
  logic [7:0]    w_rdat [NUM_EP];
  logic [PW-1:0] w_cnt_s;
  logic [PW-1:0] w_free_s;
  logic [7:0]    w_rdat_s;
  logic [7:0]    w_alt_s;

  logic          r_rxact;
  logic          r_txact;
  logic          r_pkt_ok;
  logic          r_fin_seen;
  logic [3:0]    r_rx_ep;
  logic [3:0]    r_tx_ep;
  len_t          r_len;
  logic [7:0]    r_alt [NUM_INF];

  assign w_rst = reset_i | usbrst_i;
  assign w_rx_fall = r_rxact & ~rxact_i;
  assign w_rx_ok = r_pkt_ok | rxpktval_i;
  assign w_tx_rise = txact_i & ~r_txact;
  assign w_tx_fall = r_txact & ~txact_i;
  assign w_any_sel = |w_sel;

  for (genvar n = 0; n < NUM_EP; n++) begin : g_ep
    assign w_sel[n] = ~setup_i & (endpt_i != EP0)
                    & (endpt_i == 4'(n + 1));
    usb_ep_fifo #(
      .DEPTH(DEPTH),
      .MPS(MPS)
    ) u_fifo (
      .i_clk(clk_i),
      .i_rst(w_rst),
      .i_wr(rxact_i & rxval_i & w_sel[n]),
      .i_wdat(rxdat_i),
      .i_rx_end(w_rx_fall & (r_rx_ep == 4'(n + 1))),
      .i_rx_ok(w_rx_ok),
      .i_pop(txpop_i & w_sel[n]),
      .i_fin(txpktfin_i & (r_tx_ep == 4'(n + 1))),
      .i_tx_abort(w_tx_fall & ~r_fin_seen & ~txpktfin_i
                  & (r_tx_ep == 4'(n + 1))),
      .o_count(w_cnt[n]),
      .o_free(w_free[n]),
      .o_rdat(w_rdat[n]),
      .o_ovf(ovf_o[n])
    );
  end

  // Select the addressed endpoint's status and data
  always_comb begin
    w_cnt_s = '0;
    w_free_s = '0;
    w_rdat_s = '0;
    for (int n = 0; n < NUM_EP; n++) begin
      if (w_sel[n]) begin
        w_cnt_s = w_cnt[n];
        w_free_s = w_free[n];
        w_rdat_s = w_rdat[n];
      end
    end
  end

  // Look up the alternate setting for the selected interface
  always_comb begin
    w_alt_s = '0;
    for (int i = 0; i < NUM_INF; i++) begin
      if (inf_sel_i == 8'(i)) begin
        w_alt_s = r_alt[i];
      end
    end
  end

  assign rxrdy_o = w_rst
                 | (w_any_sel & (w_free_s >= PW'(MPS)));
  assign txval_o = ~w_rst & w_any_sel & (w_cnt_s != '0);
  assign txcork_o = ~txval_o;
  assign txdat_o = txval_o ? w_rdat_s : 8'd0;
  assign txdat_len_o = w_rst ? 12'd0 : r_len;
  assign inf_alter_o = w_rst ? 8'd0 : w_alt_s;

  // Transfer edge tracking, packet status and IN length latch
  always_ff @(posedge clk_i) begin
    if (w_rst) begin
      r_rxact <= 1'b0;
      r_txact <= 1'b0;
      r_pkt_ok <= 1'b0;
      r_fin_seen <= 1'b0;
      r_rx_ep <= '0;
      r_tx_ep <= '0;
      r_len <= '0;
    end else begin
      r_rxact <= rxact_i;
      r_txact <= txact_i;
      if (rxact_i) r_rx_ep <= endpt_i;
      if (txact_i) r_tx_ep <= endpt_i;
      if (w_rx_fall) begin
        r_pkt_ok <= 1'b0;
      end else if (rxpktval_i) begin
        r_pkt_ok <= 1'b1;
      end
      if (w_tx_fall) begin
        r_fin_seen <= 1'b0;
      end else if (txpktfin_i) begin
        r_fin_seen <= 1'b1;
      end
      if (w_tx_rise) begin
        r_len <= (w_cnt_s > PW'(MPS)) ? len_t'(MPS)
                                      : len_t'(w_cnt_s);
      end else if (w_tx_fall) begin
        r_len <= '0;
      end
    end
  end

  // Alternate-setting register file
  always_ff @(posedge clk_i) begin
    if (w_rst) begin
      for (int i = 0; i < NUM_INF; i++) r_alt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_INF; i++) begin
        if (inf_set_i && inf_sel_i == 8'(i)) begin
          r_alt[i] <= inf_alter_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_usb_ep_loopback.sv
// Directed bench for usb_ep_loopback.
// Inputs change and outputs are sampled on the falling edge.
module tb_usb_ep_loopback;

  logic        clk_i = 1'b0;
  logic        reset_i, usbrst_i;
  logic        rxact_i, rxval_i, rxpktval_i, setup_i;
  logic [7:0]  rxdat_i;
  logic [3:0]  endpt_i;
  logic        rxrdy_o;
  logic        txact_i, txpop_i, txpktfin_i;
  logic [7:0]  txdat_o;
  logic        txval_o, txcork_o;
  logic [11:0] txdat_len_o;
  logic        inf_set_i;
  logic [7:0]  inf_sel_i, inf_alter_i, inf_alter_o;
  logic [1:0]  ovf_o;

  int total = 0;
  int bad = 0;

  usb_ep_loopback #(
    .NUM_EP(2), .NUM_INF(2), .DEPTH(1024), .MPS(512)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .usbrst_i(usbrst_i),
    .rxact_i(rxact_i), .rxval_i(rxval_i), .rxdat_i(rxdat_i),
    .rxpktval_i(rxpktval_i), .setup_i(setup_i),
    .endpt_i(endpt_i), .rxrdy_o(rxrdy_o),
    .txact_i(txact_i), .txpop_i(txpop_i),
    .txpktfin_i(txpktfin_i), .txdat_o(txdat_o),
    .txval_o(txval_o), .txdat_len_o(txdat_len_o),
    .txcork_o(txcork_o), .inf_set_i(inf_set_i),
    .inf_sel_i(inf_sel_i), .inf_alter_i(inf_alter_i),
    .inf_alter_o(inf_alter_o), .ovf_o(ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic out_pkt(input logic [3:0] ep, input int n,
                         input int start, input bit good,
                         input bit setup);
    endpt_i = ep;
    setup_i = setup;
    rxact_i = 1'b1;
    @(negedge clk_i);
    for (int i = 0; i < n; i++) begin
      rxval_i = 1'b1;
      rxdat_i = 8'(start + i);
      @(negedge clk_i);
    end
    rxval_i = 1'b0;
    rxpktval_i = good;
    @(negedge clk_i);
    rxpktval_i = 1'b0;
    rxact_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    setup_i = 1'b0;
  endtask

  task automatic in_pkt(input logic [3:0] ep, input int n,
                        input int start, input bit fin,
                        input int exp_len, input string tag);
    int errs = 0;
    endpt_i = ep;
    txact_i = 1'b1;
    @(negedge clk_i);
    chk({tag, "_len"}, 32'(txdat_len_o), exp_len);
    for (int i = 0; i < n; i++) begin
      if (txdat_o !== 8'(start + i)) errs++;
      txpop_i = 1'b1;
      @(negedge clk_i);
    end
    txpop_i = 1'b0;
    chk({tag, "_byte_errs"}, errs, 0);
    if (fin) begin
      txpktfin_i = 1'b1;
      @(negedge clk_i);
      txpktfin_i = 1'b0;
    end
    txact_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    reset_i = 1'b1; usbrst_i = 1'b0;
    rxact_i = 1'b0; rxval_i = 1'b0; rxdat_i = '0;
    rxpktval_i = 1'b0; setup_i = 1'b0; endpt_i = 4'd1;
    txact_i = 1'b0; txpop_i = 1'b0; txpktfin_i = 1'b0;
    inf_set_i = 1'b0; inf_sel_i = '0; inf_alter_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_rxrdy", rxrdy_o, 1);
    chk("rst_txval", txval_o, 0);
    chk("rst_cork", txcork_o, 1);
    chk("rst_len", txdat_len_o, 0);
    chk("rst_dat", txdat_o, 0);
    chk("rst_alt", inf_alter_o, 0);
    chk("rst_ovf", ovf_o, 0);
    reset_i = 1'b0;
    @(negedge clk_i);

    // good 10-byte OUT on EP1
    out_pkt(4'd1, 10, 0, 1'b1, 1'b0);
    endpt_i = 4'd1;
    #1 chk("t1_txval", txval_o, 1);
    chk("t1_cork", txcork_o, 0);

    // bad-CRC OUT on EP2 rolls back
    out_pkt(4'd2, 8, 8'h80, 1'b0, 1'b0);
    endpt_i = 4'd2;
    #1 chk("t2_ep2_txval", txval_o, 0);
    chk("t2_ep2_rxrdy", rxrdy_o, 1);
    endpt_i = 4'd1;
    #1 chk("t2_ep1_txval", txval_o, 1);
    @(negedge clk_i);

    in_pkt(4'd1, 10, 0, 1'b1, 10, "t1_in");
    endpt_i = 4'd1;
    #1 chk("t1_empty_txval", txval_o, 0);
    chk("t1_empty_cork", txcork_o, 1);
    @(negedge clk_i);

    // 600 bytes: unacked IN retries with the same data
    out_pkt(4'd1, 600, 0, 1'b1, 1'b0);
    in_pkt(4'd1, 512, 0, 1'b0, 512, "t3_try");
    in_pkt(4'd1, 512, 0, 1'b1, 512, "t3_retry");
    in_pkt(4'd1, 88, 512, 1'b1, 88, "t3_tail");
    endpt_i = 4'd1;
    #1 chk("t3_empty", txval_o, 0);
    @(negedge clk_i);

    // fill to 1000, then overflow a 30-byte packet
    out_pkt(4'd1, 500, 0, 1'b1, 1'b0);
    #1 chk("t4_rxrdy_500", rxrdy_o, 1);
    @(negedge clk_i);
    out_pkt(4'd1, 500, 500, 1'b1, 1'b0);
    #1 chk("t4_rxrdy_1000", rxrdy_o, 0);
    chk("t4_ovf_pre", ovf_o, 0);
    @(negedge clk_i);
    out_pkt(4'd1, 30, 8'hc0, 1'b1, 1'b0);
    #1 chk("t4_ovf", ovf_o, 2'b01);
    chk("t4_rxrdy_after", rxrdy_o, 0);
    @(negedge clk_i);
    in_pkt(4'd1, 512, 0, 1'b1, 512, "t4_in1");
    in_pkt(4'd1, 488, 512, 1'b1, 488, "t4_in2");
    endpt_i = 4'd1;
    #1 chk("t4_empty", txval_o, 0);
    chk("t4_ovf_sticky", ovf_o, 2'b01);
    @(negedge clk_i);

    // alternate settings
    inf_set_i = 1'b1; inf_sel_i = 8'd1; inf_alter_i = 8'd3;
    @(negedge clk_i);
    inf_sel_i = 8'd5; inf_alter_i = 8'd7;
    @(negedge clk_i);
    inf_sel_i = 8'd0; inf_alter_i = 8'd9;
    @(negedge clk_i);
    inf_set_i = 1'b0; inf_sel_i = 8'd1;
    #1 chk("t5_alt1", inf_alter_o, 3);
    inf_sel_i = 8'd5;
    #1 chk("t5_alt5", inf_alter_o, 0);
    inf_sel_i = 8'd0;
    #1 chk("t5_alt0", inf_alter_o, 9);
    @(negedge clk_i);
    out_pkt(4'd2, 4, 8'h20, 1'b1, 1'b0);
    endpt_i = 4'd2;
    #1 chk("t5_ep2_pre", txval_o, 1);
    @(negedge clk_i);
    usbrst_i = 1'b1;
    @(negedge clk_i);
    usbrst_i = 1'b0;
    @(negedge clk_i);
    chk("t5_ep2_post", txval_o, 0);
    chk("t5_ep2_rxrdy", rxrdy_o, 1);
    chk("t5_ovf_clr", ovf_o, 0);
    inf_sel_i = 8'd1;
    #1 chk("t5_alt1_clr", inf_alter_o, 0);
    inf_sel_i = 8'd0;
    #1 chk("t5_alt0_clr", inf_alter_o, 0);
    @(negedge clk_i);

    // invalid endpoints and SETUP
    endpt_i = 4'd0;
    #1 chk("t6_ep0_rxrdy", rxrdy_o, 0);
    chk("t6_ep0_cork", txcork_o, 1);
    @(negedge clk_i);
    out_pkt(4'd0, 4, 8'h40, 1'b1, 1'b0);
    endpt_i = 4'd3;
    #1 chk("t6_ep3_rxrdy", rxrdy_o, 0);
    @(negedge clk_i);
    out_pkt(4'd3, 4, 8'h48, 1'b1, 1'b0);
    setup_i = 1'b1; endpt_i = 4'd1;
    #1 chk("t6_setup_rxrdy", rxrdy_o, 0);
    chk("t6_setup_txval", txval_o, 0);
    @(negedge clk_i);
    out_pkt(4'd1, 4, 8'h50, 1'b1, 1'b1);
    endpt_i = 4'd1;
    #1 chk("t6_ep1_txval", txval_o, 0);
    chk("t6_ep1_rxrdy", rxrdy_o, 1);
    endpt_i = 4'd2;
    #1 chk("t6_ep2_txval", txval_o, 0);
    chk("t6_ovf", ovf_o, 0);
    @(negedge clk_i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
